param_exec_datapath: RTL and testbench

- Parametrised multi-cycle execute datapath: register bank, X/Y operand latches, ALU, T result latch and V/C/Z/S flag register, sequenced by an internal FSM.
- Generalises the existing 16-bit single-configuration datapath and register bank to configurable width and register count.
- Adds a start/busy/done handshake, an immediate operand path, an external register-load port and a debug read port.
- Sits between the control unit and memory interface; the control unit issues one operation at a time.

---
 rtl/param_exec_datapath.sv | 159 +++++++++++++++
 tb/tb_param_exec_datapath.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_exec_datapath.sv
// Multi-cycle execute datapath: register bank, X/Y operand latches, ALU, T latch and
// V/C/Z/S flags, sequenced by a four-state FSM with start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; external register writes accepted
// READ  | X/Y latch operands from the register bank or immediate
// EXEC  | T and flags load the ALU output
// WB    | T written to R[rd] (unless rd = 0)
module param_exec_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic                     imm_sel,
  input  logic [WIDTH-1:0]         imm,
  input  logic                     ext_we,
  input  logic [$clog2(NREGS)-1:0] ext_addr,
  input  logic [WIDTH-1:0]         ext_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     v,
  output logic                     c,
  output logic                     z,
  output logic                     s
);

  localparam int AW  = $clog2(NREGS);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t           state_q, state_d;
  logic             busy_q, done_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    rs1_q, rs2_q, rd_q;
  logic             imm_sel_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] x_q, y_q, t_q;
  logic             v_q, c_q, z_q, s_q;
  logic [WIDTH-1:0] rf_q [NREGS];

  logic             accept, ext_ok;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_t;
  logic             alu_c, alu_v;

  // busy/done are registered from the previous state, so the done cycle is spent in
  // IDLE with busy still high; new requests are taken only once busy has dropped.
  assign accept = start && (state_q == S_IDLE) && !busy_q;
  assign ext_ok = ext_we && (state_q == S_IDLE) && !busy_q && (ext_addr != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_READ;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sum   = '0;
    alu_t = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (op_q)
      3'b000: begin
        sum   = {1'b0, x_q} + {1'b0, y_q};
        alu_t = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (x_q[MSB] == y_q[MSB]) && (alu_t[MSB] != x_q[MSB]);
      end
      3'b001: begin
        alu_t = x_q - y_q;
        alu_c = (x_q >= y_q);
        alu_v = (x_q[MSB] != y_q[MSB]) && (alu_t[MSB] != x_q[MSB]);
      end
      3'b010: alu_t = x_q & y_q;
      3'b011: alu_t = x_q | y_q;
      3'b100: alu_t = x_q ^ y_q;
      3'b101: alu_t = ~x_q;
      3'b110: begin
        alu_t = {x_q[WIDTH-2:0], 1'b0};
        alu_c = x_q[MSB];
      end
      3'b111: alu_t = {{(WIDTH-1){1'b0}}, ($signed(x_q) < $signed(y_q))};
      default: alu_t = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      t_q       <= '0;
      v_q       <= 1'b0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      s_q       <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_q != S_IDLE);
      done_q  <= (state_q == S_WB);
      if (accept) begin
        op_q      <= op;
        rs1_q     <= rs1;
        rs2_q     <= rs2;
        rd_q      <= rd;
        imm_sel_q <= imm_sel;
        imm_q     <= imm;
      end
      if (state_q == S_READ) begin
        x_q <= rf_q[rs1_q];
        y_q <= imm_sel_q ? imm_q : rf_q[rs2_q];
      end
      if (state_q == S_EXEC) begin
        t_q <= alu_t;
        v_q <= alu_v;
        c_q <= alu_c;
        z_q <= (alu_t == '0);
        s_q <= alu_t[MSB];
      end
      // R0 is never written, so it holds its reset value of zero.
      if ((state_q == S_WB) && (rd_q != '0)) rf_q[rd_q] <= t_q;
      else if (ext_ok) rf_q[ext_addr] <= ext_data;
    end
  end

  assign dbg_data = rf_q[dbg_addr];
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = t_q;
  assign v        = v_q;
  assign c        = c_q;
  assign z        = z_q;
  assign s        = s_q;

endmodule

// File: tb/tb_param_exec_datapath.sv
// Directed bench for param_exec_datapath: default 16x8 instance plus 8x4 and 32x16
// instances driven in lockstep for the width sweep.
module tb_param_exec_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [2:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        imm_sel = 1'b0;
  logic [15:0] imm = '0;
  logic        ext_we = 1'b0;
  logic [2:0]  ext_addr = '0;
  logic [15:0] ext_data = '0;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data, result;
  logic        busy, done, v, c, z, s;

  logic        sw_start = 1'b0;
  logic [2:0]  sw_op = '0;
  logic [3:0]  sw_rs1 = '0, sw_rs2 = '0, sw_rd = '0, sw_ext_addr = '0, sw_dbg_addr = '0;
  logic        sw_imm_sel = 1'b0, sw_ext_we = 1'b0;
  logic [31:0] sw_imm = '0, sw_ext_data = '0;
  logic [7:0]  a_dbg, a_result;
  logic        a_busy, a_done, a_v, a_c, a_z, a_s;
  logic [31:0] b_dbg, b_result;
  logic        b_busy, b_done, b_v, b_c, b_z, b_s;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  param_exec_datapath #(.WIDTH(16), .NREGS(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm_sel(imm_sel), .imm(imm), .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .done(done), .result(result),
    .v(v), .c(c), .z(z), .s(s));

  param_exec_datapath #(.WIDTH(8), .NREGS(4)) u_w8 (
    .clk(clk), .rst(rst), .start(sw_start), .op(sw_op), .rs1(sw_rs1[1:0]), .rs2(sw_rs2[1:0]),
    .rd(sw_rd[1:0]), .imm_sel(sw_imm_sel), .imm(sw_imm[7:0]), .ext_we(sw_ext_we),
    .ext_addr(sw_ext_addr[1:0]), .ext_data(sw_ext_data[7:0]), .dbg_addr(sw_dbg_addr[1:0]),
    .dbg_data(a_dbg), .busy(a_busy), .done(a_done), .result(a_result),
    .v(a_v), .c(a_c), .z(a_z), .s(a_s));

  param_exec_datapath #(.WIDTH(32), .NREGS(16)) u_w32 (
    .clk(clk), .rst(rst), .start(sw_start), .op(sw_op), .rs1(sw_rs1), .rs2(sw_rs2),
    .rd(sw_rd), .imm_sel(sw_imm_sel), .imm(sw_imm), .ext_we(sw_ext_we),
    .ext_addr(sw_ext_addr), .ext_data(sw_ext_data), .dbg_addr(sw_dbg_addr),
    .dbg_data(b_dbg), .busy(b_busy), .done(b_done), .result(b_result),
    .v(b_v), .c(b_c), .z(b_z), .s(b_s));

  // Stimulus helpers: drive one request, return latency (edges from accept to done) and busy trace.
  task automatic run_op(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] d, input logic isel, input logic [15:0] im,
                        input logic ewe, input logic [2:0] ea, input logic [15:0] ed,
                        output int lat, output logic [3:0] bz);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; rd = d; imm_sel = isel; imm = im;
    ext_we = ewe; ext_addr = ea; ext_data = ed; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; ext_we = 1'b0;
    lat = 99; bz = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i <= 4) bz[i-1] = busy;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic exec(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] d, input logic isel, input logic [15:0] im,
                      output int lat);
    logic [3:0] bz;
    run_op(o, a, b, d, isel, im, 1'b0, 3'd0, 16'd0, lat, bz);
  endtask

  task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    ext_we = 1'b1; ext_addr = a; ext_data = d;
    @(posedge clk);
    #1 ext_we = 1'b0;
  endtask

  task automatic sw_ext_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sw_ext_we = 1'b1; sw_ext_addr = a; sw_ext_data = d;
    @(posedge clk);
    #1 sw_ext_we = 1'b0;
  endtask

  task automatic sw_exec(input logic [2:0] o, input logic [3:0] d, input logic isel,
                         input logic [31:0] im, output int lat, output logic bd);
    @(negedge clk);
    sw_op = o; sw_rs1 = 4'd1; sw_rs2 = 4'd2; sw_rd = d; sw_imm_sel = isel; sw_imm = im;
    sw_start = 1'b1;
    @(posedge clk);
    #1 sw_start = 1'b0;
    lat = 99; bd = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (a_done) begin lat = i; bd = b_done; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got busy=%b done=%b want 0 0", busy, done); end
    total++; if (result !== 16'h0) begin bad++; $display("FAIL reset_result got %h want 0000", result); end
    total++; if ({v, c, z, s} !== 4'b0000) begin bad++; $display("FAIL reset_flags got %b want 0000", {v, c, z, s}); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL reset_reg R%0d got %h want 0000", i, dbg_data); end
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat; logic [3:0] bz;
    ext_write(3'd1, 16'd12);
    ext_write(3'd2, 16'd10);
    run_op(3'b000, 3'd1, 3'd2, 3'd3, 1'b0, 16'd0, 1'b0, 3'd0, 16'd0, lat, bz);
    total++; if (lat !== 4) begin bad++; $display("FAIL add_latency got %0d want 4", lat); end
    total++; if (bz !== 4'b1110) begin bad++; $display("FAIL add_busy_trace got %b want 1110", bz); end
    total++; if (result !== 16'd22) begin bad++; $display("FAIL add_result got %h want 0016", result); end
    total++; if ({v, c, z, s} !== 4'b0000) begin bad++; $display("FAIL add_flags got %b want 0000", {v, c, z, s}); end
    dbg_addr = 3'd3; #1;
    total++; if (dbg_data !== 16'd22) begin bad++; $display("FAIL add_r3 got %h want 0016", dbg_data); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL add_after_done got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_sub();
    int lat;
    exec(3'b001, 3'd2, 3'd1, 3'd4, 1'b0, 16'd0, lat);
    total++; if (result !== 16'hFFFE) begin bad++; $display("FAIL sub_neg_result got %h want fffe", result); end
    total++; if ({v, c, z, s} !== 4'b0001) begin bad++; $display("FAIL sub_neg_flags got %b want 0001", {v, c, z, s}); end
    dbg_addr = 3'd4; #1;
    total++; if (dbg_data !== 16'hFFFE) begin bad++; $display("FAIL sub_r4 got %h want fffe", dbg_data); end
    exec(3'b001, 3'd1, 3'd1, 3'd5, 1'b0, 16'd0, lat);
    total++; if (result !== 16'h0) begin bad++; $display("FAIL sub_zero_result got %h want 0000", result); end
    total++; if ({v, c, z, s} !== 4'b0110) begin bad++; $display("FAIL sub_zero_flags got %b want 0110", {v, c, z, s}); end
  endtask

  task automatic test_logic();
    logic [2:0]  ops  [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [15:0] want [6] = '{16'h0008, 16'h000E, 16'h0006, 16'hFFF3, 16'h0018, 16'h0000};
    logic [3:0]  fl   [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
    int lat;
    for (int i = 0; i < 6; i++) begin
      exec(ops[i], 3'd1, 3'd2, 3'd6, 1'b0, 16'd0, lat);
      total++; if (result !== want[i] || {v, c, z, s} !== fl[i]) begin
        bad++; $display("FAIL logic_op%0d got %h/%b want %h/%b", ops[i], result, {v, c, z, s}, want[i], fl[i]);
      end
    end
  endtask

  task automatic test_imm();
    int lat;
    ext_write(3'd6, 16'h7FFF);
    exec(3'b000, 3'd6, 3'd2, 3'd7, 1'b1, 16'd1, lat);
    total++; if (result !== 16'h8000 || {v, c, z, s} !== 4'b1001) begin bad++; $display("FAIL imm_add_ovf got %h/%b want 8000/1001", result, {v, c, z, s}); end
    ext_write(3'd6, 16'hFFFF);
    exec(3'b000, 3'd6, 3'd2, 3'd7, 1'b1, 16'd1, lat);
    total++; if (result !== 16'h0000 || {v, c, z, s} !== 4'b0110) begin bad++; $display("FAIL imm_add_wrap got %h/%b want 0000/0110", result, {v, c, z, s}); end
    ext_write(3'd6, 16'h8000);
    exec(3'b111, 3'd6, 3'd2, 3'd7, 1'b1, 16'd1, lat);
    total++; if (result !== 16'h0001 || {v, c, z, s} !== 4'b0000) begin bad++; $display("FAIL imm_slt got %h/%b want 0001/0000", result, {v, c, z, s}); end
    exec(3'b001, 3'd6, 3'd2, 3'd7, 1'b1, 16'd1, lat);
    total++; if (result !== 16'h7FFF || {v, c, z, s} !== 4'b1100) begin bad++; $display("FAIL imm_sub_ovf got %h/%b want 7fff/1100", result, {v, c, z, s}); end
  endtask

  task automatic test_r0();
    int lat;
    ext_write(3'd0, 16'h1234);
    dbg_addr = 3'd0; #1;
    total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL r0_ext got %h want 0000", dbg_data); end
    exec(3'b001, 3'd2, 3'd1, 3'd0, 1'b0, 16'd0, lat);
    total++; if (lat !== 4 || result !== 16'hFFFE || {v, c, z, s} !== 4'b0001) begin
      bad++; $display("FAIL r0_wb_op got lat=%0d %h/%b want 4 fffe/0001", lat, result, {v, c, z, s});
    end
    dbg_addr = 3'd0; #1;
    total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL r0_wb got %h want 0000", dbg_data); end
    exec(3'b000, 3'd0, 3'd2, 3'd7, 1'b1, 16'd5, lat);
    total++; if (result !== 16'd5) begin bad++; $display("FAIL r0_operand got %h want 0005", result); end
  endtask

  task automatic test_ext_with_start();
    int lat; logic [3:0] bz;
    run_op(3'b000, 3'd1, 3'd2, 3'd3, 1'b0, 16'd0, 1'b1, 3'd1, 16'd100, lat, bz);
    total++; if (result !== 16'd110) begin bad++; $display("FAIL ext_start_same got %h want 006e", result); end
    ext_write(3'd1, 16'd12);
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    exec(3'b000, 3'd1, 3'd2, 3'd3, 1'b0, 16'd0, lat1);
    exec(3'b000, 3'd3, 3'd3, 3'd4, 1'b0, 16'd0, lat2);
    total++; if (lat1 !== 4 || lat2 !== 4) begin bad++; $display("FAIL b2b_latency got %0d %0d want 4 4", lat1, lat2); end
    total++; if (result !== 16'd44) begin bad++; $display("FAIL b2b_result got %h want 002c", result); end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    ext_write(3'd5, 16'h0055);
    @(negedge clk);
    op = 3'b000; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd3; imm_sel = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 rd = 3'd5;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (i >= 3) start = 1'b0;
      ext_we = (i == 2 || i == 3); ext_addr = 3'd2; ext_data = 16'hAAAA;
    end
    ext_we = 1'b0;
    total++; if (ndone !== 1) begin bad++; $display("FAIL busy_single_done got %0d want 1", ndone); end
    dbg_addr = 3'd5; #1;
    total++; if (dbg_data !== 16'h0055) begin bad++; $display("FAIL busy_start_ignored R5 got %h want 0055", dbg_data); end
    dbg_addr = 3'd2; #1;
    total++; if (dbg_data !== 16'd10) begin bad++; $display("FAIL busy_ext_ignored R2 got %h want 000a", dbg_data); end
    dbg_addr = 3'd3; #1;
    total++; if (dbg_data !== 16'd22) begin bad++; $display("FAIL busy_first_op R3 got %h want 0016", dbg_data); end
  endtask

  task automatic test_reset_mid_op();
    int lat, ndone = 0;
    exec(3'b001, 3'd2, 3'd1, 3'd4, 1'b0, 16'd0, lat);
    @(negedge clk);
    op = 3'b000; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd5; imm_sel = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
      rst = (i == 2 || i == 3);
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL rst_mid_done got %0d want 0", ndone); end
    total++; if (busy !== 1'b0 || {v, c, z, s} !== 4'b0000 || result !== 16'h0) begin
      bad++; $display("FAIL rst_mid_state got busy=%b flags=%b t=%h want 0 0000 0000", busy, {v, c, z, s}, result);
    end
    dbg_addr = 3'd5; #1;
    total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL rst_mid_r5 got %h want 0000", dbg_data); end
  endtask

  task automatic test_sweep();
    int lat; logic bd;
    sw_ext_write(4'd1, 32'h8000_0080);
    sw_exec(3'b110, 4'd2, 1'b0, 32'd0, lat, bd);
    total++; if (lat !== 4 || bd !== 1'b1) begin bad++; $display("FAIL sweep_latency got %0d b_done=%b want 4 1", lat, bd); end
    total++; if (a_result !== 8'h00 || {a_v, a_c, a_z, a_s} !== 4'b0110) begin bad++; $display("FAIL sweep_w8_shl got %h/%b want 00/0110", a_result, {a_v, a_c, a_z, a_s}); end
    total++; if (b_result !== 32'h0000_0100 || {b_v, b_c, b_z, b_s} !== 4'b0100) begin bad++; $display("FAIL sweep_w32_shl got %h/%b want 00000100/0100", b_result, {b_v, b_c, b_z, b_s}); end
    sw_exec(3'b000, 4'd3, 1'b1, 32'hFFFF_FF90, lat, bd);
    total++; if (a_result !== 8'h10 || {a_v, a_c, a_z, a_s} !== 4'b1100) begin bad++; $display("FAIL sweep_w8_add got %h/%b want 10/1100", a_result, {a_v, a_c, a_z, a_s}); end
    total++; if (b_result !== 32'h8000_0010 || {b_v, b_c, b_z, b_s} !== 4'b0101) begin bad++; $display("FAIL sweep_w32_add got %h/%b want 80000010/0101", b_result, {b_v, b_c, b_z, b_s}); end
    sw_dbg_addr = 4'd3; #1;
    total++; if (a_dbg !== 8'h10 || b_dbg !== 32'h8000_0010) begin bad++; $display("FAIL sweep_r3 got %h %h want 10 80000010", a_dbg, b_dbg); end
    sw_exec(3'b000, 4'd3, 1'b1, 32'h7FFF_FF80, lat, bd);
    total++; if (a_result !== 8'h00 || {a_v, a_c, a_z, a_s} !== 4'b1110) begin bad++; $display("FAIL sweep_w8_wrap got %h/%b want 00/1110", a_result, {a_v, a_c, a_z, a_s}); end
    total++; if (b_result !== 32'h0 || {b_v, b_c, b_z, b_s} !== 4'b0110) begin bad++; $display("FAIL sweep_w32_wrap got %h/%b want 00000000/0110", b_result, {b_v, b_c, b_z, b_s}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_imm();
    test_r0();
    test_ext_with_start();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_op();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
